// File: rtl/ext_mem_responder.sv
`default_nettype none
// ==== ext_mem_responder : byte-array slave for the two-channel accelerator master bus ====
// ==== fixed read/write latency, OR-merged with the internal slave return path. rev 1.0 ====
module ext_mem_responder #(
  parameter int BASE_ADDR   = 0,
  parameter int MEM_BYTES   = 256,
  parameter int ADDR_W      = 9,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Mout_oe_ram,
  input  logic [1:0]          Mout_we_ram,
  input  logic [2*ADDR_W-1:0] Mout_addr_ram,
  input  logic [63:0]         Mout_Wdata_ram,
  input  logic [11:0]         Mout_data_ram_size,
  input  logic [63:0]         Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  input  logic                init_we,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic [7:0]          init_data,
  output logic [63:0]         M_Rdata_ram,
  output logic [1:0]          M_DataRdy,
  output logic                error
);

  localparam int          IDX_W   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [31:0] WIN_LO  = 32'(BASE_ADDR);
  localparam logic [31:0] WIN_HI  = 32'(BASE_ADDR + MEM_BYTES);
  localparam logic [31:0] SIZE    = 32'(MEM_BYTES);
  localparam logic [2:0]  RD_LAST = 3'(READ_DELAY - 2);
  localparam logic [2:0]  WR_LAST = 3'(WRITE_DELAY - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [7:0]       mem [MEM_BYTES];
  logic [1:0]       wr_commit;
  logic [1:0]       err_set;
  logic [1:0][31:0] offset_all;
  logic [1:0][31:0] wr_word_all;

  genvar c;
  generate
    for (c = 0; c < 2; c++) begin : g_ch
      logic [31:0] addr32;
      logic [31:0] offset;
      logic [31:0] mask;
      logic [31:0] rd_word;
      logic [31:0] rdata;
      logic [5:0]  size;
      logic        hit, oe, we;
      state_t      state_q, state_d;
      logic [2:0]  cnt_q, cnt_d;
      logic        is_rd_q, is_rd_d;
      logic        capture, done_rd, done_wr, err, rdy;
      logic [31:0] pipe [READ_DELAY-1];

      assign addr32 = 32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]);
      assign hit    = (addr32 >= WIN_LO) && (addr32 < WIN_HI);
      assign oe     = Mout_oe_ram[c] & hit;
      assign we     = Mout_we_ram[c] & hit;
      assign offset = addr32 - WIN_LO;
      assign size   = Mout_data_ram_size[c*6 +: 6];
      assign mask   = (size >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << size) - 32'd1);

      // Bytes past the end of the array read as zero.
      always_comb begin
        rd_word = '0;
        for (int b = 0; b < 4; b++) begin
          if (offset + 32'(b) < SIZE) begin
            rd_word[b*8 +: 8] = mem[IDX_W'(offset + 32'(b))];
          end
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_rd_d = is_rd_q;
        capture = 1'b0;
        done_rd = 1'b0;
        done_wr = 1'b0;
        err     = 1'b0;
        case (state_q)
          IDLE: begin
            if (oe && we) begin
              err = 1'b1;
            end else if (oe) begin
              state_d = BUSY;
              cnt_d   = '0;
              is_rd_d = 1'b1;
              capture = 1'b1;
            end else if (we) begin
              if (WRITE_DELAY == 1) begin
                done_wr = 1'b1;
              end else begin
                state_d = BUSY;
                cnt_d   = '0;
                is_rd_d = 1'b0;
              end
            end
          end
          BUSY: begin
            if (is_rd_q ? !oe : !we) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (cnt_q == (is_rd_q ? RD_LAST : WR_LAST)) begin
              done_rd = is_rd_q;
              done_wr = !is_rd_q;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          is_rd_q <= 1'b0;
          for (int i = 0; i < READ_DELAY-1; i++) pipe[i] <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          is_rd_q <= is_rd_d;
          if (capture) pipe[0] <= rd_word;
          for (int i = 1; i < READ_DELAY-1; i++) pipe[i] <= pipe[i-1];
        end
      end

      // Reset suppresses the strobe at once, including the combinational write strobe.
      assign rdy   = (done_rd | done_wr) & ~reset;
      assign rdata = (done_rd & ~reset) ? pipe[READ_DELAY-2] : '0;

      assign wr_commit[c]   = done_wr & ~reset;
      assign err_set[c]     = err;
      assign offset_all[c]  = offset;
      assign wr_word_all[c] = (Mout_Wdata_ram[c*32 +: 32] & mask) | (rd_word & ~mask);

      assign M_DataRdy[c]          = rdy | Sout_DataRdy[c];
      assign M_Rdata_ram[c*32 +: 32] = rdata | Sout_Rdata_ram[c*32 +: 32];
    end
  endgenerate

  logic [31:0] init32;
  logic        init_hit;
  assign init32   = 32'(init_addr);
  assign init_hit = (init32 >= WIN_LO) && (init32 < WIN_HI);

  // Contents survive reset; channel 1 is applied last so it wins on a shared byte.
  always_ff @(posedge clock) begin
    if (init_we && init_hit && (wr_commit == 2'b00)) begin
      mem[IDX_W'(init32 - WIN_LO)] <= init_data;
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (wr_commit[ch]) begin
        for (int b = 0; b < 4; b++) begin
          if (offset_all[ch] + 32'(b) < SIZE) begin
            mem[IDX_W'(offset_all[ch] + 32'(b))] <= wr_word_all[ch][b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (err_set != 2'b00) begin
      error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_responder.sv
`default_nettype none
// ==== tb_ext_mem_responder : directed stimulus with a queued scoreboard for ext_mem_responder ====
module tb_ext_mem_responder;

  localparam int AW = 9;

  logic clock, rst_a, rst_b;
  logic [1:0]    oe_a, we_a, oe_b, we_b;
  logic [2*AW-1:0] addr_a, addr_b;
  logic [63:0]   wdata_a, wdata_b;
  logic [11:0]   size_a, size_b;
  logic [63:0]   srdata_a, srdata_b;
  logic [1:0]    srdy_a, srdy_b;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [7:0]    init_data;
  logic [63:0]   rdata_a, rdata_b;
  logic [1:0]    rdy_a, rdy_b;
  logic          err_a, err_b;

  ext_mem_responder #(.READ_DELAY(2), .WRITE_DELAY(1)) dut_a (
    .clock(clock), .reset(rst_a), .Mout_oe_ram(oe_a), .Mout_we_ram(we_a),
    .Mout_addr_ram(addr_a), .Mout_Wdata_ram(wdata_a), .Mout_data_ram_size(size_a),
    .Sout_Rdata_ram(srdata_a), .Sout_DataRdy(srdy_a), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .M_Rdata_ram(rdata_a),
    .M_DataRdy(rdy_a), .error(err_a));

  ext_mem_responder #(.READ_DELAY(4), .WRITE_DELAY(1)) dut_b (
    .clock(clock), .reset(rst_b), .Mout_oe_ram(oe_b), .Mout_we_ram(we_b),
    .Mout_addr_ram(addr_b), .Mout_Wdata_ram(wdata_b), .Mout_data_ram_size(size_b),
    .Sout_Rdata_ram(srdata_b), .Sout_DataRdy(srdy_b), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .M_Rdata_ram(rdata_b),
    .M_DataRdy(rdy_b), .error(err_b));

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q0[$], q1[$], qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // id 0/1: instance A channel 0/1, id 2: instance B channel 0
  task automatic push(input int id, input int lat, input logic [31:0] d, input bit c, input string nm);
    exp_t e;
    e.cyc = cyc + lat; e.data = d; e.chk = c; e.name = nm;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: qb.push_back(e);
    endcase
  endtask

  task automatic mon(input int id, input logic [31:0] data);
    exp_t e;
    int   n;
    case (id)
      0: n = q0.size();
      1: n = q1.size();
      default: n = qb.size();
    endcase
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL unexpected_strobe id=%0d: got strobe at cyc=%0d data=%h required no strobe", id, cyc, data);
      return;
    end
    case (id)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = qb.pop_front();
    endcase
    if (e.cyc != cyc || (e.chk && data !== e.data)) begin
      bad++;
      $display("FAIL %s id=%0d: got cyc=%0d data=%h required cyc=%0d data=%h",
               e.name, id, cyc, data, e.cyc, e.data);
    end
  endtask

  always @(negedge clock) begin
    if (rdy_a[0]) mon(0, rdata_a[31:0]);
    if (rdy_a[1]) mon(1, rdata_a[63:32]);
    if (rdy_b[0]) mon(2, rdata_b[31:0]);
  end

  task automatic set_a(input int ch, input logic [AW-1:0] a, input logic [31:0] d, input logic [5:0] s);
    addr_a[ch*AW +: AW] = a;
    wdata_a[ch*32 +: 32] = d;
    size_a[ch*6 +: 6] = s;
  endtask

  task automatic a_read(input int ch, input logic [AW-1:0] a, input logic [31:0] req, input string nm);
    set_a(ch, a, 32'h0, 6'd32);
    oe_a[ch] = 1'b1;
    push(ch, 1, req, 1'b1, nm);
    repeat (2) tick();
    oe_a[ch] = 1'b0;
  endtask

  task automatic a_write(input int ch, input logic [AW-1:0] a, input logic [31:0] d, input logic [5:0] s, input string nm);
    set_a(ch, a, d, s);
    we_a[ch] = 1'b1;
    push(ch, 0, 32'h0, 1'b0, nm);
    tick();
    we_a[ch] = 1'b0;
  endtask

  task automatic b_read(input logic [AW-1:0] a, input int hold);
    addr_b[AW-1:0] = a;
    size_b[5:0] = 6'd32;
    oe_b[0] = 1'b1;
    repeat (hold) tick();
    oe_b[0] = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    tick();
    init_we = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    oe_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; size_a = '0;
    oe_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; size_b = '0;
    srdata_a = '0; srdy_a = '0; srdata_b = '0; srdy_b = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    repeat (2) tick();
    chk("reset_rdy",   {62'h0, rdy_a},   64'h0);
    chk("reset_rdata", rdata_a,          64'h0);
    chk("reset_error", {63'h0, err_a},   64'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) preload(AW'(i), 8'h00);
    preload(9'h010, 8'h11); preload(9'h011, 8'h22);
    preload(9'h012, 8'h33); preload(9'h013, 8'h44);
    preload(9'h0FE, 8'hAB); preload(9'h0FF, 8'hCD);
    preload(9'h150, 8'hEE);  // outside the window: ignored

    a_read(0, 9'h010, 32'h4433_2211, "rd_preload");
    a_write(1, 9'h020, 32'hAABB_CCDD, 6'd8, "wr_size8");
    a_read(1, 9'h020, 32'h0000_00DD, "rd_after_size8");

    set_a(0, 9'h030, 32'h1, 6'd32); set_a(1, 9'h030, 32'h2, 6'd32);
    we_a = 2'b11;
    push(0, 0, 32'h0, 1'b0, "wr_dual_ch0"); push(1, 0, 32'h0, 1'b0, "wr_dual_ch1");
    tick();
    we_a = 2'b00;
    a_read(0, 9'h030, 32'h0000_0002, "rd_dual_ch1_wins");

    a_write(0, 9'h040, 32'h1234_5678, 6'd16, "wr_size16");
    a_read(0, 9'h040, 32'h0000_5678, "rd_after_size16");

    a_read(1, 9'h0FE, 32'h0000_CDAB, "rd_edge");
    a_write(1, 9'h0FF, 32'h1122_3344, 6'd32, "wr_edge");
    a_read(1, 9'h0FE, 32'h0000_44AB, "rd_edge_after_wr");

    init_we = 1'b1; init_addr = 9'h050; init_data = 8'h77;
    a_write(0, 9'h060, 32'hFFFF_FFFF, 6'd32, "wr_vs_init");
    init_we = 1'b0;
    a_read(0, 9'h050, 32'h0000_0000, "rd_init_dropped");
    a_read(0, 9'h060, 32'hFFFF_FFFF, "rd_wr_vs_init");
    preload(9'h051, 8'h66);
    a_read(0, 9'h050, 32'h0000_6600, "rd_init_alone");

    // Read and write of the same byte in one cycle: read sees the old byte.
    set_a(0, 9'h010, 32'h0, 6'd32); set_a(1, 9'h010, 32'h99, 6'd8);
    oe_a[0] = 1'b1; we_a[1] = 1'b1;
    push(0, 1, 32'h4433_2211, 1'b1, "rd_pre_write");
    push(1, 0, 32'h0, 1'b0, "wr_same_byte");
    tick();
    we_a[1] = 1'b0;
    tick();
    oe_a[0] = 1'b0;
    a_read(0, 9'h010, 32'h4433_2299, "rd_post_write");

    set_a(0, 9'h014, 32'hFFFF_FFFF, 6'd32);
    oe_a[0] = 1'b1; we_a[0] = 1'b1;
    repeat (3) tick();
    chk("error_set", {63'h0, err_a}, 64'h1);
    oe_a[0] = 1'b0; we_a[0] = 1'b0;
    repeat (3) tick();
    chk("error_sticky", {63'h0, err_a}, 64'h1);
    a_read(0, 9'h014, 32'h0000_0000, "rd_after_error");
    rst_a = 1'b1;
    #1;
    chk("error_cleared", {63'h0, err_a}, 64'h0);
    tick();
    rst_a = 1'b0;
    tick();
    a_read(0, 9'h010, 32'h4433_2299, "rd_mem_kept_over_reset");

    set_a(0, 9'h104, 32'h0, 6'd32);
    oe_a[0] = 1'b1;
    srdy_a[0] = 1'b1; srdata_a[31:0] = 32'h0000_005A;
    push(0, 0, 32'h0000_005A, 1'b1, "miss_passthrough");
    tick();
    srdy_a[0] = 1'b0; srdata_a[31:0] = 32'h0;
    repeat (4) tick();
    oe_a[0] = 1'b0;
    tick();

    push(2, 3, 32'h4433_2211, 1'b1, "b_rd_delay4");
    b_read(9'h010, 4);
    b_read(9'h010, 2);  // dropped before completion: no strobe
    repeat (4) tick();

    b_read(9'h010, 3);
    oe_b[0] = 1'b1;
    rst_b = 1'b1;
    #1;
    chk("b_reset_rdy",   {62'h0, rdy_b}, 64'h0);
    chk("b_reset_rdata", rdata_b,        64'h0);
    oe_b[0] = 1'b0;
    repeat (2) tick();
    rst_b = 1'b0;
    tick();
    push(2, 3, 32'h4433_2211, 1'b1, "b_rd_after_reset");
    b_read(9'h010, 4);

    repeat (6) tick();
    for (int i = 0; i < q0.size(); i++) begin
      total++; bad++;
      $display("FAIL missing_strobe %s: got none required strobe at cyc=%0d", q0[i].name, q0[i].cyc);
    end
    for (int i = 0; i < q1.size(); i++) begin
      total++; bad++;
      $display("FAIL missing_strobe %s: got none required strobe at cyc=%0d", q1[i].name, q1[i].cyc);
    end
    for (int i = 0; i < qb.size(); i++) begin
      total++; bad++;
      $display("FAIL missing_strobe %s: got none required strobe at cyc=%0d", qb[i].name, qb[i].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
